// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU-side request/response and RAM-side word port of the
// load/store unit, bundled as one interface.
//   CPU side : req, we, funct3, addr, wdata (to LSU); rdata, resp_valid, stall (from LSU)
//   RAM side : ram_de, ram_we, ram_a, ram_wd (from LSU); ram_rd (to LSU)
//   MISALIGN_TRAP_EN adds misaligned (from LSU).
// Modports: slave = the LSU itself, master = the environment driving it.
`timescale 1ns/1ps

interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  resp_valid;
    logic                  stall;
    logic                  ram_de;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [31:0]           ram_wd;
    logic [31:0]           ram_rd;
`ifdef MISALIGN_TRAP_EN
    logic                  misaligned;
`endif

    modport slave (
        input  req, we, funct3, addr, wdata, ram_rd,
        output rdata, resp_valid, stall, ram_de, ram_we, ram_a, ram_wd
`ifdef MISALIGN_TRAP_EN
        , output misaligned
`endif
    );

    modport master (
        output req, we, funct3, addr, wdata, ram_rd,
        input  rdata, resp_valid, stall, ram_de, ram_we, ram_a, ram_wd
`ifdef MISALIGN_TRAP_EN
        , input misaligned
`endif
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the CPU memory stage to a word-write-only data RAM.
// Extends sub-word loads, places store lanes, and turns SB/SH into a
// read-modify-write (one stall cycle, then a MERGE write cycle).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - load_store_unit_if.slave (CPU request/response + RAM port)
// Optional: define MISALIGN_TRAP_EN to trap misaligned/reserved accesses
//   (bus.misaligned pulses with resp_valid, RAM untouched).
`timescale 1ns/1ps

module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    load_store_unit_if.slave       bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  mis_q, mis_d;

    logic [1:0]            off;
    logic                  is_byte, is_half, is_unsigned, mis_acc;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           lane_ext, merged;

    // Access decode, load lane extraction and store lane merge
    always_comb begin
        off         = bus.addr[1:0];
        is_byte     = (bus.funct3[1:0] == 2'b00);
        is_half     = (bus.funct3[1:0] == 2'b01);
        is_unsigned = bus.funct3[2];
        word_addr   = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef MISALIGN_TRAP_EN
        mis_acc = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                  (bus.funct3 == 3'b111) || (is_half && bus.addr[0]) ||
                  (!is_byte && !is_half && (off != 2'b00));
`else
        mis_acc = 1'b0;
`endif
        byte_v = bus.ram_rd[{off, 3'b000} +: 8];
        half_v = bus.ram_rd[{bus.addr[1], 4'b0000} +: 16];
        if (is_byte) begin
            lane_ext = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        end else if (is_half) begin
            lane_ext = {{16{~is_unsigned & half_v[15]}}, half_v};
        end else begin
            lane_ext = bus.ram_rd;
        end
        merged = bus.ram_rd;
        if (is_byte) begin
            merged[{off, 3'b000} +: 8] = bus.wdata[7:0];
        end else begin
            merged[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
        end
    end

    // Next-state and RAM/stall outputs. The merged word and its address are
    // captured at the read phase so MERGE does not depend on the CPU still
    // presenting the store once stall has dropped.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        wa_d       = wa_q;
        rdata_d    = rdata_q;
        resp_d     = 1'b0;
        mis_d      = 1'b0;
        bus.ram_de = 1'b0;
        bus.ram_we = 1'b0;
        bus.ram_a  = '0;
        bus.ram_wd = 32'h0;
        bus.stall  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        if (mis_acc) begin
                            resp_d = 1'b1;
                            mis_d  = 1'b1;
                        end else begin
                            bus.ram_de = 1'b1;
                            bus.ram_a  = word_addr;
                            if (!bus.we) begin
                                rdata_d = lane_ext;
                                resp_d  = 1'b1;
                            end else if (is_byte || is_half) begin
                                bus.stall = 1'b1;
                                buf_d     = merged;
                                wa_d      = word_addr;
                                state_d   = MERGE;
                            end else begin
                                bus.ram_we = 1'b1;
                                bus.ram_wd = bus.wdata;
                                resp_d     = 1'b1;
                            end
                        end
                    end
                end
                MERGE: begin
                    bus.ram_de = 1'b1;
                    bus.ram_we = 1'b1;
                    bus.ram_a  = wa_q;
                    bus.ram_wd = buf_q;
                    resp_d     = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= 32'h0;
            wa_q    <= '0;
            rdata_q <= 32'h0;
            resp_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            wa_q    <= wa_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.misaligned = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule
